// File: rtl/corelet_ctrl_pkg.sv
// Shared types and constants for the corelet sequencing controller.
package corelet_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_W_FILL = 4'd1,
      ST_W_LOAD = 4'd2,
      ST_SKEW   = 4'd3,
      ST_X_RUN  = 4'd4,
      ST_OS_RUN = 4'd5,
      ST_FLUSH  = 4'd6,
      ST_DRAIN  = 4'd7,
      ST_DONE   = 4'd8
   } state_e;

   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   localparam logic MODE_WS = 1'b0;
   localparam logic MODE_OS = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/corelet_ctrl_addr_gen.sv
// Bank address generator: loads a base on start, post-increments per issued read, wraps naturally.
module corelet_ctrl_addr_gen #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic [ADDR_WIDTH-1:0] addr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
      end else if (load_i) begin
         addr_q <= base_i;
      end else if (inc_i) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer for WS/OS tiles: bank addressing, L0/IFIFO/array control, psum drain tracking.
// Build macro CORELET_CTRL_STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module corelet_ctrl
   import corelet_ctrl_pkg::*;
#(
   parameter int ROW        = 8,
   parameter int COL        = 8,
   parameter int LEN_ONIJ   = 16,
   parameter int LEN_KIJ    = 9,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  mode_i,
   input  logic [ADDR_WIDTH-1:0] x_base_i,
   input  logic [ADDR_WIDTH-1:0] w_base_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  x_rd_en_o,
   output logic                  w_rd_en_o,
   output logic [ADDR_WIDTH-1:0] x_addr_o,
   output logic [ADDR_WIDTH-1:0] w_addr_o,
   output logic                  execution_mode_o,
   output logic                  bank_selector_o,
   output logic                  l0_wr_en_o,
   output logic                  l0_rd_en_o,
   input  logic                  l0_wr_ready_i,
   input  logic                  l0_rd_ready_i,
   output logic                  ififo_wr_en_o,
   output logic                  ififo_rd_en_o,
   input  logic                  ififo_wr_ready_i,
   input  logic                  ififo_rd_ready_i,
   output logic [1:0]            inst_o,
   output logic                  weight_overwrite_o,
   output logic [COL-1:0]        shift_psum_o,
   input  logic                  d_valid_i,
   output logic [15:0]           stall_cnt_o
);

   localparam int CW = $clog2(max3(LEN_ONIJ, LEN_KIJ, COL) + 1);
   localparam int WW = $clog2(ROW + COL + 1);
   localparam logic [CW-1:0] COL_C      = CW'(COL);
   localparam logic [CW-1:0] COL_LAST   = CW'(COL - 1);
   localparam logic [CW-1:0] ONIJ_C     = CW'(LEN_ONIJ);
   localparam logic [CW-1:0] KIJ_C      = CW'(LEN_KIJ);
   localparam logic [CW-1:0] EXP_OS_C   = CW'(ROW);
   localparam logic [WW-1:0] SKEW_LAST  = WW'(ROW + COL - 1);
   localparam logic [WW-1:0] FLUSH_LAST = WW'(ROW - 1);

   state_e        state_q, state_d;
   logic          mode_q;
   logic [CW-1:0] issue_cnt_q, wr_cnt_q, rd_cnt_q, drain_cnt_q, drain_cnt_d;
   logic [WW-1:0] wait_cnt_q;
   logic          l0_wr_en_q, ififo_wr_en_q;
   logic          x_issue, w_issue, l0_rd, start_ok, phase_change;

   assign start_ok     = (state_q == ST_IDLE) && start_i;
   assign phase_change = (state_d != state_q);

   // Reads are only issued while the destination can accept them; OS issues and consumes in pairs.
   always_comb begin
      x_issue = 1'b0;
      w_issue = 1'b0;
      l0_rd   = 1'b0;
      case (state_q)
         ST_W_FILL: w_issue = l0_wr_ready_i && (issue_cnt_q < COL_C);
         ST_W_LOAD: l0_rd   = l0_rd_ready_i && (rd_cnt_q < COL_C);
         ST_X_RUN: begin
            x_issue = l0_wr_ready_i && (issue_cnt_q < ONIJ_C);
            l0_rd   = l0_rd_ready_i && (rd_cnt_q < ONIJ_C);
         end
         ST_OS_RUN: begin
            x_issue = l0_wr_ready_i && ififo_wr_ready_i && (issue_cnt_q < KIJ_C);
            w_issue = x_issue;
            l0_rd   = l0_rd_ready_i && ififo_rd_ready_i && (rd_cnt_q < KIJ_C);
         end
         default: ;
      endcase
   end

   always_comb begin
      drain_cnt_d = drain_cnt_q;
      if (d_valid_i && (drain_cnt_q != '1)) begin
         drain_cnt_d = drain_cnt_q + CW'(1);
      end
   end

   // Run phases end on counted L0 writes so the last delayed write lands before moving on.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = (mode_i == MODE_WS) ? ST_W_FILL : ST_OS_RUN;
         ST_W_FILL: if (w_issue && (issue_cnt_q == COL_LAST)) state_d = ST_W_LOAD;
         ST_W_LOAD: if (l0_rd && (rd_cnt_q == COL_LAST)) state_d = ST_SKEW;
         ST_SKEW:   if (wait_cnt_q == SKEW_LAST) state_d = (mode_q == MODE_OS) ? ST_FLUSH : ST_X_RUN;
         ST_X_RUN:  if ((wr_cnt_q == ONIJ_C) && (rd_cnt_q == ONIJ_C)) state_d = ST_DRAIN;
         ST_OS_RUN: if ((wr_cnt_q == KIJ_C) && (rd_cnt_q == KIJ_C)) state_d = ST_SKEW;
         ST_FLUSH:  if (wait_cnt_q == FLUSH_LAST) state_d = ST_DRAIN;
         ST_DRAIN:  if (drain_cnt_d >= ((mode_q == MODE_OS) ? EXP_OS_C : ONIJ_C)) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_WS;
         l0_wr_en_q    <= 1'b0;
         ififo_wr_en_q <= 1'b0;
         issue_cnt_q   <= '0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         wait_cnt_q    <= '0;
         drain_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         l0_wr_en_q    <= x_issue || (w_issue && (state_q == ST_W_FILL));
         ififo_wr_en_q <= w_issue && (state_q == ST_OS_RUN);
         if (start_ok) begin
            mode_q      <= mode_i;
            drain_cnt_q <= '0;
         end else if (state_q != ST_IDLE) begin
            drain_cnt_q <= drain_cnt_d;
         end
         if (phase_change) begin
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
         end else begin
            if (x_issue || w_issue) issue_cnt_q <= issue_cnt_q + CW'(1);
            if (l0_wr_en_q)         wr_cnt_q    <= wr_cnt_q + CW'(1);
            if (l0_rd)              rd_cnt_q    <= rd_cnt_q + CW'(1);
            if ((state_q == ST_SKEW) || (state_q == ST_FLUSH)) wait_cnt_q <= wait_cnt_q + WW'(1);
         end
      end
   end

   corelet_ctrl_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_x_addr (
      .clk    (clk),
      .reset  (reset),
      .load_i (start_ok),
      .base_i (x_base_i),
      .inc_i  (x_issue),
      .addr_o (x_addr_o)
   );

   corelet_ctrl_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr (
      .clk    (clk),
      .reset  (reset),
      .load_i (start_ok),
      .base_i (w_base_i),
      .inc_i  (w_issue),
      .addr_o (w_addr_o)
   );

   assign busy_o             = (state_q != ST_IDLE);
   assign done_o             = (state_q == ST_DONE);
   assign x_rd_en_o          = x_issue;
   assign w_rd_en_o          = w_issue;
   assign execution_mode_o   = mode_q;
   assign bank_selector_o    = (state_q == ST_X_RUN) || (state_q == ST_OS_RUN);
   assign l0_wr_en_o         = l0_wr_en_q;
   assign l0_rd_en_o         = l0_rd;
   assign ififo_wr_en_o      = ififo_wr_en_q;
   assign ififo_rd_en_o      = l0_rd && (state_q == ST_OS_RUN);
   assign inst_o             = !l0_rd ? INST_IDLE : ((state_q == ST_W_LOAD) ? INST_KLOAD : INST_EXEC);
   assign weight_overwrite_o = l0_rd && (state_q == ST_W_LOAD);
   assign shift_psum_o       = {COL{state_q == ST_FLUSH}};

`ifdef CORELET_CTRL_STALL_CNT_EN
   logic        blocked;
   logic [15:0] stall_cnt_q;

   // A cycle counts as stalled when some still-owed issue is held off by a low ready.
   always_comb begin
      blocked = 1'b0;
      case (state_q)
         ST_W_FILL: blocked = !l0_wr_ready_i && (issue_cnt_q < COL_C);
         ST_W_LOAD: blocked = !l0_rd_ready_i && (rd_cnt_q < COL_C);
         ST_X_RUN:  blocked = (!l0_wr_ready_i && (issue_cnt_q < ONIJ_C)) ||
                              (!l0_rd_ready_i && (rd_cnt_q < ONIJ_C));
         ST_OS_RUN: blocked = (!(l0_wr_ready_i && ififo_wr_ready_i) && (issue_cnt_q < KIJ_C)) ||
                              (!(l0_rd_ready_i && ififo_rd_ready_i) && (rd_cnt_q < KIJ_C));
         default:   blocked = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (start_ok) begin
         stall_cnt_q <= '0;
      end else if (blocked && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed self-checking bench for corelet_ctrl: WS, OS, stall/wrap, reset abort, busy start.
module tb_corelet_ctrl;

`ifdef CORELET_CTRL_STALL_CNT_EN
   localparam int EXP_STALL = 5;
`else
   localparam int EXP_STALL = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start_i, mode_i, d_valid_i;
   logic [7:0] x_base_i, w_base_i;
   logic       l0_wr_ready_i, l0_rd_ready_i, ififo_wr_ready_i, ififo_rd_ready_i;
   logic       busy_o, done_o, x_rd_en_o, w_rd_en_o, execution_mode_o, bank_selector_o;
   logic [7:0] x_addr_o, w_addr_o, shift_psum_o;
   logic       l0_wr_en_o, l0_rd_en_o, ififo_wr_en_o, ififo_rd_en_o, weight_overwrite_o;
   logic [1:0] inst_o;
   logic [15:0] stall_cnt_o;

   always #5 clk = ~clk;

   corelet_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .start_i            (start_i),
      .mode_i             (mode_i),
      .x_base_i           (x_base_i),
      .w_base_i           (w_base_i),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .x_rd_en_o          (x_rd_en_o),
      .w_rd_en_o          (w_rd_en_o),
      .x_addr_o           (x_addr_o),
      .w_addr_o           (w_addr_o),
      .execution_mode_o   (execution_mode_o),
      .bank_selector_o    (bank_selector_o),
      .l0_wr_en_o         (l0_wr_en_o),
      .l0_rd_en_o         (l0_rd_en_o),
      .l0_wr_ready_i      (l0_wr_ready_i),
      .l0_rd_ready_i      (l0_rd_ready_i),
      .ififo_wr_en_o      (ififo_wr_en_o),
      .ififo_rd_en_o      (ififo_rd_en_o),
      .ififo_wr_ready_i   (ififo_wr_ready_i),
      .ififo_rd_ready_i   (ififo_rd_ready_i),
      .inst_o             (inst_o),
      .weight_overwrite_o (weight_overwrite_o),
      .shift_psum_o       (shift_psum_o),
      .d_valid_i          (d_valid_i),
      .stall_cnt_o        (stall_cnt_o)
   );

   int nChecks = 0;
   int nErrors = 0;
   int nKload, nExec, nDone, nFlush, nL0Wr, nIfWr, nIfRd, nPair, nWo, nInstBad, nSelBad, nModeBad;
   logic       expMode;
   logic [7:0] xAddrs[$];
   logic [7:0] wAddrs[$];

   // Every comparison funnels through here so the counters always match the printed summary.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] allOut();
      return {11'd0, busy_o, done_o, x_rd_en_o, w_rd_en_o, x_addr_o, w_addr_o, execution_mode_o,
              bank_selector_o, l0_wr_en_o, l0_rd_en_o, ififo_wr_en_o, ififo_rd_en_o, inst_o,
              weight_overwrite_o, shift_psum_o, stall_cnt_o};
   endfunction

   task automatic clearTally();
      nKload = 0; nExec = 0; nDone = 0; nFlush = 0; nL0Wr = 0; nIfWr = 0; nIfRd = 0;
      nPair = 0; nWo = 0; nInstBad = 0; nSelBad = 0; nModeBad = 0;
      xAddrs.delete();
      wAddrs.delete();
   endtask

   // Inputs are set just after a rising edge; outputs are tallied on the falling edge.
   task automatic step();
      @(negedge clk);
      if (w_rd_en_o) wAddrs.push_back(w_addr_o);
      if (x_rd_en_o) xAddrs.push_back(x_addr_o);
      if (x_rd_en_o && w_rd_en_o) nPair++;
      if (inst_o == 2'b01) nKload++;
      if (inst_o == 2'b10) nExec++;
      if ((inst_o != 2'b00) && !l0_rd_en_o) nInstBad++;
      if (weight_overwrite_o) nWo++;
      if (done_o) nDone++;
      if (shift_psum_o == 8'hFF) nFlush++;
      if (l0_wr_en_o) nL0Wr++;
      if (ififo_wr_en_o) nIfWr++;
      if (ififo_rd_en_o) nIfRd++;
      if ((w_rd_en_o && !x_rd_en_o && bank_selector_o) || (x_rd_en_o && !bank_selector_o)) nSelBad++;
      if (busy_o && (execution_mode_o !== expMode)) nModeBad++;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic mode, input logic [7:0] xb, input logic [7:0] wb);
      mode_i   = mode;
      x_base_i = xb;
      w_base_i = wb;
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
   endtask

   task automatic drainPulses(input int n);
      for (int i = 0; i < n; i++) begin
         d_valid_i = 1'b1;
         step();
         d_valid_i = 1'b0;
         step();
      end
   endtask

   initial begin
      logic [7:0] e;
      reset = 1'b1; start_i = 1'b0; mode_i = 1'b0; d_valid_i = 1'b0;
      x_base_i = 8'h00; w_base_i = 8'h00; expMode = 1'b0;
      l0_wr_ready_i = 1'b1; l0_rd_ready_i = 1'b1; ififo_wr_ready_i = 1'b1; ififo_rd_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", allOut(), 64'd0);
      reset = 1'b0;

      $display("[TB] WS tile, readies high");
      clearTally(); expMode = 1'b0;
      applyStimulus(1'b0, 8'h10, 8'h40);
      for (int i = 0; i < 200 && nExec < 16; i++) step();
      checkOutput("ws_w_reads", wAddrs.size(), 8);
      for (int i = 0; i < wAddrs.size(); i++) checkOutput($sformatf("ws_w_addr%0d", i), wAddrs[i], 64'(8'h40 + i));
      checkOutput("ws_kload", nKload, 8);
      checkOutput("ws_overwrite", nWo, 8);
      checkOutput("ws_exec", nExec, 16);
      checkOutput("ws_x_reads", xAddrs.size(), 16);
      for (int i = 0; i < xAddrs.size(); i++) checkOutput($sformatf("ws_x_addr%0d", i), xAddrs[i], 64'(8'h10 + i));
      drainPulses(15);
      checkOutput("ws_no_early_done", nDone, 0);
      drainPulses(1);
      checkOutput("ws_done_after_16", nDone, 1);
      repeat (3) step();
      checkOutput("ws_single_done", nDone, 1);
      checkOutput("ws_busy_low", busy_o, 0);
      checkOutput("ws_l0_writes", nL0Wr, 24);
      checkOutput("ws_no_ififo", nIfWr + nIfRd, 0);
      checkOutput("ws_inst_rd", nInstBad, 0);
      checkOutput("ws_bank_sel", nSelBad, 0);
      checkOutput("ws_mode", nModeBad, 0);
      checkOutput("ws_stall", stall_cnt_o, 0);

      $display("[TB] OS tile, readies high");
      clearTally(); expMode = 1'b1;
      applyStimulus(1'b1, 8'h20, 8'h80);
      for (int i = 0; i < 200 && nFlush < 8; i++) step();
      checkOutput("os_pairs", nPair, 9);
      checkOutput("os_x_reads", xAddrs.size(), 9);
      checkOutput("os_w_reads", wAddrs.size(), 9);
      for (int i = 0; i < xAddrs.size(); i++) checkOutput($sformatf("os_x_addr%0d", i), xAddrs[i], 64'(8'h20 + i));
      for (int i = 0; i < wAddrs.size(); i++) checkOutput($sformatf("os_w_addr%0d", i), wAddrs[i], 64'(8'h80 + i));
      checkOutput("os_exec", nExec, 9);
      checkOutput("os_kload", nKload, 0);
      checkOutput("os_ififo_wr", nIfWr, 9);
      checkOutput("os_ififo_rd", nIfRd, 9);
      checkOutput("os_l0_wr", nL0Wr, 9);
      checkOutput("os_flush_cycles", nFlush, 8);
      drainPulses(7);
      checkOutput("os_no_early_done", nDone, 0);
      drainPulses(1);
      checkOutput("os_done_after_8", nDone, 1);
      repeat (3) step();
      checkOutput("os_single_done", nDone, 1);
      checkOutput("os_flush_total", nFlush, 8);
      checkOutput("os_mode", nModeBad, 0);
      checkOutput("os_bank_sel", nSelBad, 0);

      $display("[TB] WS tile with L0 write stall and x address wrap");
      clearTally(); expMode = 1'b0;
      applyStimulus(1'b0, 8'hFE, 8'h00);
      for (int i = 0; i < 200 && nExec < 4; i++) step();
      checkOutput("stall_pre_reads", xAddrs.size(), 4);
      l0_wr_ready_i = 1'b0;
      repeat (5) step();
      checkOutput("stall_no_x_reads", xAddrs.size(), 4);
      l0_wr_ready_i = 1'b1;
      for (int i = 0; i < 200 && xAddrs.size() < 16; i++) step();
      checkOutput("stall_x_reads", xAddrs.size(), 16);
      for (int i = 0; i < xAddrs.size(); i++) begin
         e = 8'hFE + 8'(i);
         checkOutput($sformatf("wrap_x_addr%0d", i), xAddrs[i], 64'(e));
      end
      drainPulses(16);
      repeat (2) step();
      checkOutput("stall_done", nDone, 1);
      checkOutput("stall_count", stall_cnt_o, EXP_STALL);

      $display("[TB] reset during X_RUN");
      clearTally(); expMode = 1'b0;
      applyStimulus(1'b0, 8'h10, 8'h40);
      for (int i = 0; i < 200 && nExec < 3; i++) step();
      checkOutput("abort_reached_run", nExec, 3);
      reset = 1'b1;
      #1;
      checkOutput("abort_outputs", allOut(), 64'd0);
      clearTally();
      repeat (2) step();
      checkOutput("abort_no_done", nDone, 0);
      reset = 1'b0;

      $display("[TB] OS tile after reset with start pulsed while busy");
      clearTally(); expMode = 1'b1;
      applyStimulus(1'b1, 8'h30, 8'h90);
      repeat (3) step();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput("busy_start_mode", execution_mode_o, 1);
      for (int i = 0; i < 200 && nFlush < 8; i++) step();
      checkOutput("busy_start_pairs", nPair, 9);
      for (int i = 0; i < xAddrs.size(); i++) checkOutput($sformatf("busy_x_addr%0d", i), xAddrs[i], 64'(8'h30 + i));
      drainPulses(8);
      repeat (3) step();
      checkOutput("busy_start_done", nDone, 1);
      checkOutput("busy_start_mode_all", nModeBad, 0);
      checkOutput("busy_start_idle", busy_o, 0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Sequencing controller for one corelet (L0 + IFIFO + MAC array + SFP) in either weight-stationary (WS) or output-stationary (OS) mode.
- Generates x/w bank read addresses.
- Generates all corelet enables/instructions.
- Counts drained psums and reports done.
- Sits between the top-level host/sequencer and the corelet, one instance per corelet.

Parameters:
row, 8, input channels (L0 vector width in bw lanes)
col, 8, output channels
len_onij, 16, activation vectors per WS tile
len_kij, 9, accumulation steps per OS tile
addr_width, 8, bank address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse; accepted only in IDLE
mode_i  in  1  0 = WS, 1 = OS; sampled with start_i
x_base_i, w_base_i  in  addr_width  bank start addresses; sampled with start_i
busy_o  out  1  high from accepted start until DONE exits
done_o  out  1  one-cycle pulse at tile completion
x_rd_en_o, w_rd_en_o  out  1  bank read strobes; data returns next cycle
x_addr_o, w_addr_o  out  addr_width  bank addresses
execution_mode_o  out  1  latched mode_i, held stable while busy
bank_selector_o  out  1  L0 source: 1 = x bank, 0 = w bank
l0_wr_en_o, l0_rd_en_o  out  1  L0 enables
l0_wr_ready_i, l0_rd_ready_i  in  1  L0 status
ififo_wr_en_o, ififo_rd_en_o  out  1  IFIFO enables (OS only)
ififo_wr_ready_i, ififo_rd_ready_i  in  1  IFIFO status
inst_o  out  2  bit0 = kernel load, bit1 = execute
weight_overwrite_o  out  1  array weight overwrite
shift_psum_o  out  col  per-column psum flush
d_valid_i  in  1  SFP output valid
stall_cnt_o  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset (asynchronous): state IDLE; all outputs and counters 0.
- Reset mid-operation: abort immediately, no done_o.
- start_i while busy: ignored.
- Bank-read rule: a read is issued in cycle t only if the target FIFO's wr_ready is high in cycle t. The matching wr_en is asserted in cycle t+1 unconditionally; the FIFO contract guarantees one entry of slack after ready drops. Addresses post-increment per issued read, wrapping modulo 2^addr_width.
- FIFO read rule: a read asserts only when the corresponding rd_ready is high. inst_o is asserted in the same cycle as l0_rd_en_o, else 2'b00.
- States:
  - IDLE: on start_i, latch mode and bases, clear counters. Go to W_FILL if mode = 0, else OS_RUN.
  - W_FILL (WS): bank_selector_o = 0; issue col w-bank reads; then W_LOAD.
  - W_LOAD: l0 reads with inst_o = 2'b01 and weight_overwrite_o = 1, col times; then wait row + col skew cycles; then X_RUN.
  - X_RUN: bank_selector_o = 1. x reads/L0 writes overlap with L0 reads, inst_o = 2'b10. Ends after len_onij writes and len_onij reads; then DRAIN with expected = len_onij.
  - OS_RUN: bank_selector_o = 1. Paired x read + w read each issued only when both wr_ready signals are high. Paired L0 and IFIFO reads only when both rd_ready signals are high, inst_o = 2'b10. After len_kij pairs, wait row + col skew cycles; then FLUSH.
  - FLUSH: shift_psum_o = all ones for row cycles; then DRAIN with expected = row.
  - DRAIN: count d_valid_i pulses; at expected go to DONE.
  - DONE: done_o = 1 for one cycle; busy_o drops; back to IDLE.
- Simultaneous write and read on L0 in the same cycle is legal.
- A d_valid_i pulse outside DRAIN is counted toward expected: drain counter runs from the first run state onward.
- Counters are sized $clog2(max(len_onij, len_kij, col) + 1).

Optional Feature:
CORELET_CTRL_STALL_CNT_EN
- Defined: stall_cnt_o counts cycles while busy in which a pending issue was blocked by a ready low. The count saturates at 0xFFFF and clears on accepted start.
- Undefined: stall_cnt_o is tied to 0 and no counter logic exists.

Decomposition:
- Package corelet_ctrl_pkg holds:
  - the state enum;
  - inst constants INST_IDLE = 2'b00, INST_KLOAD = 2'b01, INST_EXEC = 2'b10;
  - mode constants MODE_WS, MODE_OS.
- One sub-module, corelet_ctrl_addr_gen, instanced twice (x, w): base load, increment-on-issue, wrap.

Test Plan:
- WS, all readies held high, x_base = 0x10, w_base = 0x40:
  - W_FILL issues w_addr 0x40..0x47;
  - 8 inst = 01 cycles, then 16 inst = 10 cycles;
  - 16 d_valid pulses -> exactly one done_o.
- OS, len_kij = 9:
  - 9 paired x/w reads;
  - shift_psum_o = 0xFF for 8 cycles;
  - 8 d_valid pulses -> done_o.
- l0_wr_ready low for 5 cycles mid X_RUN:
  - no x_rd_en_o during the gap;
  - address sequence continuous;
  - stall_cnt_o = 5 with macro defined, 0 without.
- x_base = 0xFE in WS: x_addr_o wraps 0xFE, 0xFF, 0x00, ...
- reset asserted in X_RUN: all outputs 0 in the same cycle, no done_o; a new start afterwards completes normally.
- start_i pulsed while busy: ignored, latched mode unchanged, single done_o.
